// File: rtl/vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// vga_sync_monitor
//   Watches a VGA-style hsync/vsync pair and measures line length, hsync
//   width, frame height and vsync width. It compares them against the
//   expected timing and declares lock after LOCK_FRAMES consecutive good
//   frames. All sampling is qualified by pix_ce, so the monitor can run from
//   a clock faster than the pixel rate.
//
// Ports
//   clk          : the only clock
//   rst          : synchronous, active-high reset
//   pix_ce       : pixel-clock enable; sync inputs are sampled only when high
//   hsync/vsync  : raw sync inputs, polarity set by SYNC_ACTIVE_LOW
//   locked       : high while the FSM is in LOCKED
//   frame_strobe : one-clk pulse after every evaluated vsync leading edge
//   frame_err    : one-clk pulse on a bad frame or timeout while LOCKED
//   err_count    : saturating count of frame_err pulses
//   h_total_meas : samples per line, latched at each hsync leading edge
//   hsync_w_meas : active hsync samples, latched at each hsync trailing edge
//   v_total_meas : lines per frame, latched at each vsync leading edge
//   vsync_w_meas : lines with vsync active, latched at vsync trailing edge
// -----------------------------------------------------------------------------
module vga_sync_monitor #(
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter int H_SYNC          = 96,
    parameter int V_SYNC          = 2,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic        hsync,
    input  logic        vsync,
    output logic        locked,
    output logic        frame_strobe,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic [11:0] h_total_meas,
    output logic [11:0] hsync_w_meas,
    output logic [10:0] v_total_meas,
    output logic [10:0] vsync_w_meas
);

    localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
    localparam logic [11:0] H_TMO_C   = 12'(2 * H_TOTAL);
    localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
    localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
    localparam logic [10:0] V_TMO_C   = 11'(2 * V_TOTAL);
    localparam logic [7:0]  LOCK_C    = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic        hs_r_q, vs_r_q;
    logic        hs_prev_q, vs_prev_q, hist_q;
    logic [11:0] hcnt_q, hcnt_d, hw_cnt_q, hw_cnt_d;
    logic [11:0] h_total_q, h_total_d, hsync_w_q, hsync_w_d;
    logic [10:0] vcnt_q, vcnt_d, vw_cnt_q, vw_cnt_d;
    logic [10:0] v_total_q, v_total_d, vsync_w_q, vsync_w_d;
    logic        line_bad_q, line_bad_d, line_bad_now;
    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d, err_q, err_d;
    logic        strobe_q, strobe_d, ferr_q, ferr_d, locked_q;
    logic        hs_act, vs_act, hs_lead, hs_trail, vs_lead, vs_trail;
    logic        tmo, frame_ok;

    // Normalise to active-high; edges need one sample of history after reset.
    assign hs_act   = (SYNC_ACTIVE_LOW != 0) ? ~hs_r_q : hs_r_q;
    assign vs_act   = (SYNC_ACTIVE_LOW != 0) ? ~vs_r_q : vs_r_q;
    assign hs_lead  = pix_ce & hist_q &  hs_act & ~hs_prev_q;
    assign hs_trail = pix_ce & hist_q & ~hs_act &  hs_prev_q;
    assign vs_lead  = pix_ce & hist_q &  vs_act & ~vs_prev_q;
    assign vs_trail = pix_ce & hist_q & ~vs_act &  vs_prev_q;

    always_comb begin
        hcnt_d       = hcnt_q;
        hw_cnt_d     = hw_cnt_q;
        h_total_d    = h_total_q;
        hsync_w_d    = hsync_w_q;
        vcnt_d       = vcnt_q;
        vw_cnt_d     = vw_cnt_q;
        v_total_d    = v_total_q;
        vsync_w_d    = vsync_w_q;
        line_bad_now = line_bad_q;
        line_bad_d   = line_bad_q;
        tmo          = 1'b0;
        if (pix_ce) begin
            hcnt_d = hs_lead ? 12'd1 : sat_inc12(hcnt_q);
            if (hs_lead) h_total_d = hcnt_q;
            if (hs_lead)     hw_cnt_d = 12'd1;
            else if (hs_act) hw_cnt_d = sat_inc12(hw_cnt_q);
            if (hs_trail) hsync_w_d = hw_cnt_q;

            if (vs_lead)      vcnt_d = 11'd1;
            else if (hs_lead) vcnt_d = sat_inc11(vcnt_q);
            if (vs_lead) v_total_d = vcnt_q;
            if (vs_lead)                vw_cnt_d = hs_lead ? 11'd1 : 11'd0;
            else if (vs_act && hs_lead) vw_cnt_d = sat_inc11(vw_cnt_q);
            if (vs_trail) vsync_w_d = vw_cnt_q;

            // The line closed by this sample counts toward the frame being
            // evaluated on a coincident vsync edge, then the flag restarts.
            line_bad_now = line_bad_q
                         | (hs_lead  && (hcnt_q   != H_TOTAL_C))
                         | (hs_trail && (hw_cnt_q != H_SYNC_C));
            line_bad_d   = vs_lead ? 1'b0 : line_bad_now;

            // Fire once, on the sample where a counter arrives at its limit.
            tmo = ((hcnt_d == H_TMO_C) && (hcnt_q != H_TMO_C))
                | ((vcnt_d == V_TMO_C) && (vcnt_q != V_TMO_C));
        end
    end

    assign frame_ok = ~line_bad_now && (vcnt_q == V_TOTAL_C) && (vsync_w_q == V_SYNC_C);

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        err_d    = err_q;
        strobe_d = 1'b0;
        ferr_d   = 1'b0;
        if (pix_ce) begin
            if (tmo) begin
                if (state_q == LOCKED) begin
                    ferr_d = 1'b1;
                    err_d  = sat_inc8(err_q);
                end
                state_d = SEARCH;
                good_d  = 8'd0;
            end else if (vs_lead) begin
                unique case (state_q)
                    SEARCH: begin
                        state_d = MEASURE;
                        good_d  = 8'd0;
                    end
                    MEASURE: begin
                        strobe_d = 1'b1;
                        if (frame_ok) begin
                            good_d = good_q + 8'd1;
                            if ((good_q + 8'd1) >= LOCK_C) state_d = LOCKED;
                        end else begin
                            good_d = 8'd0;
                        end
                    end
                    LOCKED: begin
                        strobe_d = 1'b1;
                        if (!frame_ok) begin
                            state_d = MEASURE;
                            good_d  = 8'd0;
                            ferr_d  = 1'b1;
                            err_d   = sat_inc8(err_q);
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end
    end

    // Input capture stage: raw syncs registered once, every clk.
    always_ff @(posedge clk) begin
        hs_r_q <= hsync;
        vs_r_q <= vsync;
    end

    // Sample stage: history, counters, measurements and FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev_q  <= 1'b0;
            vs_prev_q  <= 1'b0;
            hist_q     <= 1'b0;
            hcnt_q     <= '0;
            hw_cnt_q   <= '0;
            h_total_q  <= '0;
            hsync_w_q  <= '0;
            vcnt_q     <= '0;
            vw_cnt_q   <= '0;
            v_total_q  <= '0;
            vsync_w_q  <= '0;
            line_bad_q <= 1'b0;
            state_q    <= SEARCH;
            good_q     <= '0;
            err_q      <= '0;
            strobe_q   <= 1'b0;
            ferr_q     <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            if (pix_ce) begin
                hs_prev_q <= hs_act;
                vs_prev_q <= vs_act;
                hist_q    <= 1'b1;
            end
            hcnt_q     <= hcnt_d;
            hw_cnt_q   <= hw_cnt_d;
            h_total_q  <= h_total_d;
            hsync_w_q  <= hsync_w_d;
            vcnt_q     <= vcnt_d;
            vw_cnt_q   <= vw_cnt_d;
            v_total_q  <= v_total_d;
            vsync_w_q  <= vsync_w_d;
            line_bad_q <= line_bad_d;
            state_q    <= state_d;
            good_q     <= good_d;
            err_q      <= err_d;
            strobe_q   <= strobe_d;
            ferr_q     <= ferr_d;
            locked_q   <= (state_d == LOCKED);
        end
    end

    assign locked       = locked_q;
    assign frame_strobe = strobe_q;
    assign frame_err    = ferr_q;
    assign err_count    = err_q;
    assign h_total_meas = h_total_q;
    assign hsync_w_meas = hsync_w_q;
    assign v_total_meas = v_total_q;
    assign vsync_w_meas = vsync_w_q;

endmodule

// File: doc/vga_sync_monitor.md
VGA_SYNC_MONITOR -- requirements
Module: vga_sync_monitor

Interface
REQ-001 Parameter H_TOTAL, default 800, expected pixel clocks per line.
REQ-002 Parameter V_TOTAL, default 525, expected lines per frame.
REQ-003 Parameter H_SYNC, default 96, expected hsync width in pixel clocks.
REQ-004 Parameter V_SYNC, default 2, expected vsync width in lines.
REQ-005 Parameter SYNC_ACTIVE_LOW, default 1, meaning 1 = sync pulses are low-active.
REQ-006 Parameter LOCK_FRAMES, default 2, meaning consecutive good frames required to assert locked.
REQ-007 Ports: clk in 1 (the only clock); rst in 1 (synchronous, active-high); pix_ce in 1 (pixel-clock enable, sampling qualifier); hsync in 1; vsync in 1.
REQ-008 Ports out: locked 1; frame_strobe 1 (one-clk pulse); frame_err 1 (one-clk pulse); err_count 8; h_total_meas 12; hsync_w_meas 12; v_total_meas 11; vsync_w_meas 11.

Function
REQ-009 hsync/vsync SHALL be registered once, converted to active-high per SYNC_ACTIVE_LOW, and sampled only on clk edges with pix_ce=1; edges SHALL be detected between consecutive pix_ce samples.
REQ-010 hcnt (12 b) SHALL load 1 on the sample containing an hsync leading edge, else increment per sample, saturating at 4095.
REQ-011 At each hsync leading edge, h_total_meas SHALL load the hcnt value before reload (samples from previous leading edge inclusive to this one exclusive).
REQ-012 hsync_w_meas SHALL load the count of active-hsync samples at each hsync trailing edge, saturating at 4095.
REQ-013 vcnt (11 b) SHALL count hsync leading edges, reloaded to 1 at the line on which a vsync leading edge occurs, saturating at 2047; v_total_meas SHALL load the pre-reload value at each vsync leading edge.
REQ-014 vsync_w_meas SHALL load the number of hsync leading edges seen while vsync active, at the vsync trailing edge.
REQ-015 line_bad flag SHALL set when any h_total_meas != H_TOTAL or hsync_w_meas != H_SYNC within a frame, and clear at each vsync leading edge after evaluation.
REQ-016 frame_ok SHALL be: no line_bad AND v_total_meas == V_TOTAL AND vsync_w_meas == V_SYNC, evaluated at each vsync leading edge.
REQ-017 FSM states SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-018 SEARCH -> MEASURE on first vsync leading edge; no evaluation, no frame_strobe for that edge.
REQ-019 MEASURE, vsync leading edge: frame_ok increments good_cnt; when good_cnt reaches LOCK_FRAMES -> LOCKED; not ok clears good_cnt, stays MEASURE.
REQ-020 LOCKED, vsync leading edge with not frame_ok -> MEASURE, good_cnt=0.
REQ-021 frame_strobe SHALL pulse one clk after every evaluated vsync leading edge (MEASURE/LOCKED).
REQ-022 frame_err SHALL pulse coincident with frame_strobe when frame_ok=0 while in LOCKED; err_count SHALL then increment, saturating at 255.
REQ-023 Timeout: hcnt reaching 2*H_TOTAL, or vcnt reaching 2*V_TOTAL, SHALL force SEARCH, good_cnt=0; in LOCKED it SHALL also pulse frame_err and increment err_count.
REQ-024 locked SHALL equal (state == LOCKED), registered.
REQ-025 Simultaneous hsync and vsync leading edges SHALL process the line end first, then the frame evaluation, in the same sample.
REQ-026 pix_ce=0 SHALL freeze all counters and the FSM; pulses SHALL still be one clk wide.

Reset
REQ-027 rst=1 on a clk edge SHALL clear all counters, measurements, err_count, good_cnt, pulses and locked to 0, set state SEARCH, and discard input history (no edge detected on first post-reset sample).
REQ-028 Reset asserted mid-frame or while LOCKED SHALL take effect the same clk, without frame_err.

Verification
REQ-029 Ideal 800x525 timing, pix_ce every 2nd clk: after 1 skipped + 2 evaluated frames locked=1; h_total_meas=800, hsync_w_meas=96, v_total_meas=525, vsync_w_meas=2, err_count=0.
REQ-030 Locked, then one line of 799: that frame's strobe carries frame_err=1, err_count=1, locked=0; two further good frames re-lock.
REQ-031 Locked, hsync held inactive: at hcnt=1600 state SEARCH, locked=0, frame_err pulse, err_count+1.
REQ-032 SYNC_ACTIVE_LOW=0 with positive pulses: same results as REQ-029; inverted-polarity stimulus never locks (hsync_w_meas=704).
REQ-033 rst pulsed mid-frame while locked: next clk all outputs 0, no frame_err; relock after 3 vsync edges.
REQ-034 err_count at 255 plus further bad frames: stays 255, frame_err still pulses.
